serial_mag_comparator: RTL and testbench

SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

---
 rtl/serial_mag_comparator.sv | 150 +++++++++++++++
 tb/tb_serial_mag_comparator.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator
//   Digit-serial magnitude comparator. Operands are captured on an accepted
//   start and compared one DIGIT-bit digit per cycle, most significant digit
//   first. A Lt/Gt cascade carries the decision from digit to digit.
//   Two's-complement compare is done by flipping both sign bits at capture,
//   which maps the signed range onto the unsigned range monotonically.
//
// Handshake: start is accepted only when the FSM is IDLE (busy=0). done is a
//   one-cycle pulse on the completion cycle; Lt/Gt/Eq are valid from that
//   cycle and hold until the next accepted start clears them.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   start              comparison request (sampled in IDLE)
//   signed_mode        1 = two's complement, 0 = unsigned (sampled with start)
//   A, B               operands (sampled with start)
//   busy               high while RUN
//   done               one-cycle completion pulse
//   Lt, Gt, Eq         registered result, exactly one set after done
//   stateDbg           current FSM state (0 = IDLE, 1 = RUN)
module serial_mag_comparator #(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 1,
  parameter int EARLY_EXIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             Lt,
  output logic             Gt,
  output logic             Eq,
  output logic             stateDbg
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  state_t             stateNext;
  logic [WIDTH-1:0]   opA;
  logic [WIDTH-1:0]   opB;
  logic [CNT_W-1:0]   digitCnt;
  logic               cLt;
  logic               cGt;
  logic [DIGIT-1:0]   digA;
  logic [DIGIT-1:0]   digB;
  logic               stepLt;
  logic               stepGt;
  logic               lastStep;
  logic               finish;
  logic               accept;
  logic [WIDTH-1:0]   signFlip;

  // Operands shift left each step, so the current digit is always on top.
  assign digA = opA[WIDTH-1 -: DIGIT];
  assign digB = opB[WIDTH-1 -: DIGIT];

  assign accept   = (state == IDLE) && start;
  assign signFlip = WIDTH'(signed_mode) << (WIDTH - 1);
  assign lastStep = (digitCnt == CNT_W'(N - 1));

  // Cascade cell: an earlier decision wins; otherwise this digit decides.
  always_comb begin
    stepLt = cLt;
    stepGt = cGt;
    if (!cLt && !cGt) begin
      stepLt = (digA < digB);
      stepGt = (digA > digB);
    end
  end

  always_comb begin
    finish = 1'b0;
    if (state == RUN) begin
      finish = lastStep || ((EARLY_EXIT != 0) && (stepLt || stepGt));
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // FSM next state
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (start)  stateNext = RUN;
      RUN:  if (finish) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opA      <= '0;
      opB      <= '0;
      digitCnt <= '0;
      cLt      <= 1'b0;
      cGt      <= 1'b0;
      Lt       <= 1'b0;
      Gt       <= 1'b0;
      Eq       <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        opA      <= A ^ signFlip;
        opB      <= B ^ signFlip;
        digitCnt <= '0;
        cLt      <= 1'b0;
        cGt      <= 1'b0;
        Lt       <= 1'b0;
        Gt       <= 1'b0;
        Eq       <= 1'b0;
      end else if (state == RUN) begin
        cLt      <= stepLt;
        cGt      <= stepGt;
        opA      <= opA << DIGIT;
        opB      <= opB << DIGIT;
        digitCnt <= digitCnt + CNT_W'(1);
        if (finish) begin
          Lt   <= stepLt;
          Gt   <= stepGt;
          Eq   <= ~(stepLt | stepGt);
          done <= 1'b1;
        end
      end
    end
  end

  assign busy     = (state == RUN);
  assign stateDbg = state;

endmodule

// File: tb/tb_serial_mag_comparator.sv
module tb_serial_mag_comparator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  // inst 0: W8 D1 EE0, inst 1: W8 D1 EE1, inst 2: W16 D4 EE0
  logic        start0, start1, start2;
  logic        sm0, sm1, sm2;
  logic [7:0]  a0, b0, a1, b1;
  logic [15:0] a2, b2;
  logic [2:0]  busyV, doneV, ltV, gtV, eqV, dbgV;

  serial_mag_comparator #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .signed_mode(sm0), .A(a0), .B(b0),
    .busy(busyV[0]), .done(doneV[0]), .Lt(ltV[0]), .Gt(gtV[0]), .Eq(eqV[0]),
    .stateDbg(dbgV[0]));

  serial_mag_comparator #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .signed_mode(sm1), .A(a1), .B(b1),
    .busy(busyV[1]), .done(doneV[1]), .Lt(ltV[1]), .Gt(gtV[1]), .Eq(eqV[1]),
    .stateDbg(dbgV[1]));

  serial_mag_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .signed_mode(sm2), .A(a2), .B(b2),
    .busy(busyV[2]), .done(doneV[2]), .Lt(ltV[2]), .Gt(gtV[2]), .Eq(eqV[2]),
    .stateDbg(dbgV[2]));

  // ---------------- scoreboard ----------------
  // entry: [28:27] instance, [26:11] done cycle, [10:3] latency, [2:0] {Lt,Gt,Eq}
  logic [28:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer comparison and first-differing-digit search.
  function automatic logic [10:0] refModel(input int id, input logic [15:0] aIn,
                                           input logic [15:0] bIn, input bit sm);
    int          w, d, lat, p;
    bit          ee;
    longint      va, vb;
    logic [15:0] a, b;
    w  = (id == 2) ? 16 : 8;
    d  = (id == 2) ? 4 : 1;
    ee = (id == 1);
    a  = (w == 16) ? aIn : {8'h00, aIn[7:0]};
    b  = (w == 16) ? bIn : {8'h00, bIn[7:0]};
    va = longint'(a);
    vb = longint'(b);
    if (sm && a[w-1]) va = va - (longint'(1) << w);
    if (sm && b[w-1]) vb = vb - (longint'(1) << w);
    lat = w / d;
    if (ee && (a != b)) begin
      p = w - 1;
      while (a[p] == b[p]) p--;
      lat = (w - 1 - p) / d + 1;
    end
    return {8'(lat), (va < vb), (va > vb), (va == vb)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic setIn(input int id, input logic [15:0] a, input logic [15:0] b,
                       input logic sm, input logic st);
    case (id)
      0: begin a0 = a[7:0]; b0 = b[7:0]; sm0 = sm; start0 = st; end
      1: begin a1 = a[7:0]; b1 = b[7:0]; sm1 = sm; start1 = st; end
      default: begin a2 = a; b2 = b; sm2 = sm; start2 = st; end
    endcase
  endtask

  // Called at a negedge with the DUT idle (or on its done cycle).
  task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b,
                       input bit sm);
    logic [10:0] r;
    r = refModel(id, a, b, sm);
    setIn(id, a, b, sm, 1'b1);
    exp_q.push_back({2'(id), 16'(cyc + 1 + int'(r[10:3])), r});
    @(negedge clk);
    // scramble inputs: captured operands must not follow them
    setIn(id, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
  endtask

  // Returns at the negedge where done is visible.
  task automatic waitDone(input int id);
    int n = 0;
    while (!doneV[id] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL done_timeout inst=%0d actual=no_done expected=done", id);
    end
  endtask

  task automatic runOne(input int id, input logic [15:0] a, input logic [15:0] b,
                        input bit sm);
    issue(id, a, b, sm);
    waitDone(id);
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  int       busyCnt[3];
  logic [2:0] lastRes[3];
  bit       holdValid[3];

  initial begin
    logic [28:0] e;
    logic [2:0]  res;
    for (int i = 0; i < 3; i++) begin busyCnt[i] = 0; holdValid[i] = 0; end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 3; i++) begin busyCnt[i] = 0; holdValid[i] = 0; end
      end else begin
        for (int i = 0; i < 3; i++) begin
          res = {ltV[i], gtV[i], eqV[i]};
          if (doneV[i]) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_done", 32'(i), 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              chk("done_inst", 32'(i), 32'(e[28:27]));
              chk("done_cycle", 32'(cyc), 32'(e[26:11]));
              chk("busy_cycles", 32'(busyCnt[i]), 32'(e[10:3]));
              chk("result_lt_gt_eq", 32'(res), 32'(e[2:0]));
              chk("busy_at_done", 32'(busyV[i]), 32'd0);
            end
            busyCnt[i]   = 0;
            lastRes[i]   = res;
            holdValid[i] = 1;
          end else if (busyV[i]) begin
            busyCnt[i]++;
          end else if (holdValid[i]) begin
            chk("result_hold", 32'(res), 32'(lastRes[i]));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] ra, rb;
    rst_n = 1'b0;
    setIn(0, 0, 0, 0, 0);
    setIn(1, 0, 0, 0, 0);
    setIn(2, 0, 0, 0, 0);
    #3;
    chk("reset_outputs", {17'd0, busyV, doneV, ltV, gtV, eqV}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic unsigned, signed vs unsigned interpretation
    runOne(0, 16'h00A5, 16'h00A4, 0);
    runOne(0, 16'h0080, 16'h0001, 1);
    runOne(0, 16'h0080, 16'h0001, 0);

    // early exit: first digit decides, equal operands take full length
    runOne(1, 16'h0000, 16'h0080, 0);
    runOne(1, 16'h003C, 16'h003C, 0);

    // radix-16 digits
    runOne(2, 16'h1234, 16'h1243, 0);

    // start during RUN with different operands is ignored
    issue(0, 16'h0010, 16'h0020, 0);
    @(negedge clk);
    setIn(0, 16'h00FF, 16'h0000, 1, 1);
    @(negedge clk);
    setIn(0, 16'h00FF, 16'h0000, 1, 0);
    waitDone(0);
    @(negedge clk);

    // back-to-back: second start on the done cycle
    issue(0, 16'h0055, 16'h0055, 0);
    waitDone(0);
    issue(0, 16'h0001, 16'h00FE, 1);
    waitDone(0);
    @(negedge clk);

    // reset in RUN cycle 3: everything clears at once, no done follows
    issue(0, 16'h0012, 16'h0034, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outputs", {27'd0, busyV[0], doneV[0], ltV[0], gtV[0], eqV[0]}, 32'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    runOne(0, 16'h0034, 16'h0012, 0);

    // randomized traffic on all three configurations
    for (int i = 0; i < 60; i++) begin
      runOne(0, 16'($urandom), 16'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 2))
        0: rb = ra;
        1: rb = ra ^ (16'h1 << $urandom_range(0, 7));
        default: rb = 16'($urandom);
      endcase
      runOne(1, ra, rb, 1'($urandom));
    end
    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? (ra ^ (16'h1 << $urandom_range(0, 15))) : 16'($urandom);
      runOne(2, ra, rb, 1'($urandom));
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
